circular_fifo_ctrl: RTL

//  Parametrised circular-buffer FIFO controller, next generation of our push-button FIFO.

---
 rtl/circular_fifo_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/circular_fifo_ctrl.sv
// Circular-buffer FIFO controller with occupancy count, threshold flags,
// error pulses, optional button release detectors and optional FWFT read.
module circular_fifo_ctrl #(
  parameter int DBITS     = 3,
  parameter int ABITS     = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int BTN_MODE  = 1,
  parameter int FWFT      = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] MAX_C = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_C  = (ABITS+1)'(AF_THRESH);
  localparam logic [ABITS:0] AE_C  = (ABITS+1)'(AE_THRESH);
  localparam logic [ABITS:0] ONE_C = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] PTR_ONE = ABITS'(1);

  logic             w_stb;
  logic             r_stb;
  logic             do_wr;
  logic             do_rd;
  logic             ovf_d;
  logic             unf_d;
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [DBITS-1:0] mem [DEPTH];

  if (BTN_MODE != 0) begin : g_btn
    // bit0 = newest sample; strobe fires on the release edge
    logic [1:0] ws;
    logic [1:0] rs;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        ws <= '0;
        rs <= '0;
      end else begin
        ws <= {ws[0], wr};
        rs <= {rs[0], rd};
      end
    end

    assign w_stb = ~ws[0] & ws[1];
    assign r_stb = ~rs[0] & rs[1];
  end else begin : g_lvl
    assign w_stb = wr;
    assign r_stb = rd;
  end

  assign empty        = (count == '0);
  assign full         = (count == MAX_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // at full, a same-edge read frees the slot the write lands in
  assign do_wr = w_stb & (~full | r_stb);
  assign do_rd = r_stb & ~empty;
  assign ovf_d = w_stb & full & ~r_stb;
  assign unf_d = r_stb & empty;

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_d;
      underflow <= unf_d;
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      unique case (1'b1)
        do_wr & ~do_rd: count <= count + ONE_C;
        do_rd & ~do_wr: count <= count - ONE_C;
        default: ;
      endcase
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [DBITS-1:0] dout_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
      end else if (do_rd) begin
        dout_q <= mem[rd_ptr];
      end
    end

    assign dout = dout_q;
  end

endmodule
